// File: rtl/fetch_pkg.sv
// Shared types and constants for the instruction fetch unit.
package fetch_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    HOLD = 2'd2
  } fetch_state_t;

  localparam int         INSTR_BYTES = 4;
  localparam logic [1:0] ALIGN_MASK  = 2'b11;

endpackage

// File: rtl/fetch_next_pc.sv
// Combinational next-PC select: redirect > increment > hold, with target
// word-alignment and misaligned-target detection.
module fetch_next_pc
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 12
) (
  input  logic                  hold,
  input  logic                  increment,
  input  logic                  redirect,
  input  logic [ADDR_WIDTH-1:0] current_address,
  input  logic [ADDR_WIDTH-1:0] target,
  output logic [ADDR_WIDTH-1:0] next_address,
  output logic                  misaligned
);

  localparam logic [ADDR_WIDTH-1:0] LOW_MASK = ADDR_WIDTH'(ALIGN_MASK);
  localparam logic [ADDR_WIDTH-1:0] STEP     = ADDR_WIDTH'(INSTR_BYTES);

  always_comb begin
    next_address = current_address;
    misaligned   = 1'b0;
    if (redirect) begin
      next_address = target & ~LOW_MASK;
      misaligned   = |(target & LOW_MASK);
    end else if (increment) begin
      // Wraps modulo 2^ADDR_WIDTH by truncation.
      next_address = current_address + STEP;
    end else if (hold) begin
      next_address = current_address;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch FSM: requests the word at the current PC, hands it to decode and
// chooses the next PC (hold, +4, or a branch/jump redirect).
//
// state | meaning
// IDLE  | first cycle after reset; a pending/incoming redirect may load the PC
// REQ   | imem_req high at current_address, waiting for imem_ack
// HOLD  | instr_valid high, waiting for decode to accept or a redirect
module instruction_fetch_unit
  import fetch_pkg::*;
#(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [ADDR_WIDTH-1:0] current_address,
  output logic [ADDR_WIDTH-1:0] next_address,
  output logic                  imem_req,
  output logic [ADDR_WIDTH-1:0] imem_addr,
  input  logic                  imem_ack,
  input  logic [DATA_WIDTH-1:0] imem_rdata,
  output logic [DATA_WIDTH-1:0] instr,
  output logic                  instr_valid,
  input  logic                  instr_ready,
  input  logic                  redirect_valid,
  input  logic [ADDR_WIDTH-1:0] redirect_target,
  output logic                  misaligned_fault
);

  fetch_state_t          state_q;
  logic                  imem_req_q;
  logic [DATA_WIDTH-1:0] instr_q;
  logic                  instr_valid_q;
  logic                  fault_q;
  logic                  pend_q;
  logic [ADDR_WIDTH-1:0] pend_tgt_q;

  logic                  take_redirect;
  logic                  increment;
  logic                  hold;
  logic [ADDR_WIDTH-1:0] target_sel;
  logic                  fault_d;

  // A live redirect is newer than anything pending, so it wins.
  assign target_sel = redirect_valid ? redirect_target : pend_tgt_q;

  always_comb begin
    take_redirect = 1'b0;
    increment     = 1'b0;
    case (state_q)
      IDLE: take_redirect = redirect_valid | pend_q;
      REQ:  take_redirect = imem_ack & (redirect_valid | pend_q);
      HOLD: begin
        take_redirect = redirect_valid;
        increment     = instr_valid_q & instr_ready & ~redirect_valid;
      end
      default: ;
    endcase
  end

  assign hold = ~take_redirect & ~increment;

  fetch_next_pc #(
    .ADDR_WIDTH(ADDR_WIDTH)
  ) u_next_pc (
    .hold           (hold),
    .increment      (increment),
    .redirect       (take_redirect),
    .current_address(current_address),
    .target         (target_sel),
    .next_address   (next_address),
    .misaligned     (fault_d)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      imem_req_q    <= 1'b0;
      instr_q       <= '0;
      instr_valid_q <= 1'b0;
      fault_q       <= 1'b0;
      pend_q        <= 1'b0;
      pend_tgt_q    <= '0;
    end else begin
      fault_q <= fault_d;

      // Outstanding requests are never cancelled; a redirect waits for ack.
      if (take_redirect) begin
        pend_q <= 1'b0;
      end else if (state_q == REQ && redirect_valid) begin
        pend_q     <= 1'b1;
        pend_tgt_q <= redirect_target;
      end

      case (state_q)
        IDLE: begin
          state_q    <= REQ;
          imem_req_q <= 1'b1;
        end
        REQ: begin
          if (imem_ack && !take_redirect) begin
            instr_q       <= imem_rdata;
            instr_valid_q <= 1'b1;
            imem_req_q    <= 1'b0;
            state_q       <= HOLD;
          end
        end
        HOLD: begin
          if (take_redirect || increment) begin
            instr_valid_q <= 1'b0;
            imem_req_q    <= 1'b1;
            state_q       <= REQ;
          end
        end
        default: begin
          state_q    <= IDLE;
          imem_req_q <= 1'b0;
        end
      endcase
    end
  end

  assign imem_req         = imem_req_q;
  assign imem_addr        = current_address;
  assign instr            = instr_q;
  assign instr_valid      = instr_valid_q;
  assign misaligned_fault = fault_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Directed bench for instruction_fetch_unit; the bench owns the PC register.
module tb_instruction_fetch_unit;

  localparam int AW = 12;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic [AW-1:0] pc_q;
  logic [AW-1:0] next_address;
  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [DW-1:0] imem_rdata;
  logic [DW-1:0] instr;
  logic          instr_valid;
  logic          instr_ready;
  logic          redirect_valid;
  logic [AW-1:0] redirect_target;
  logic          misaligned_fault;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) pc_q <= '0;
    else     pc_q <= next_address;
  end

  instruction_fetch_unit #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk             (clk),
    .rst             (rst),
    .current_address (pc_q),
    .next_address    (next_address),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ack        (imem_ack),
    .imem_rdata      (imem_rdata),
    .instr           (instr),
    .instr_valid     (instr_valid),
    .instr_ready     (instr_ready),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .misaligned_fault(misaligned_fault)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Inputs change 2 time units after the rising edge; checks follow 1 unit later.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  initial begin
    rst = 1'b1;
    imem_ack = 1'b0;
    imem_rdata = '0;
    instr_ready = 1'b0;
    redirect_valid = 1'b0;
    redirect_target = '0;

    tick(); tick();
    #1;
    chk("rst_req", 32'(imem_req), 32'd0);
    chk("rst_valid", 32'(instr_valid), 32'd0);
    chk("rst_instr", instr, 32'h0);
    chk("rst_fault", 32'(misaligned_fault), 32'd0);

    // cycle 0: IDLE
    rst = 1'b0;
    #1;
    chk("c0_req", 32'(imem_req), 32'd0);
    chk("c0_next", 32'(next_address), 32'h000);

    // cycle 1: zero-wait ack
    tick();
    imem_ack = 1'b1; imem_rdata = 32'h20080005; instr_ready = 1'b1;
    #1;
    chk("c1_req", 32'(imem_req), 32'd1);
    chk("c1_addr", 32'(imem_addr), 32'h000);
    chk("c1_next", 32'(next_address), 32'h000);
    chk("c1_valid", 32'(instr_valid), 32'd0);

    // cycle 2: word handed to decode, PC advances
    tick();
    imem_ack = 1'b0;
    #1;
    chk("c2_valid", 32'(instr_valid), 32'd1);
    chk("c2_instr", instr, 32'h20080005);
    chk("c2_next", 32'(next_address), 32'h004);
    chk("c2_req", 32'(imem_req), 32'd0);

    // cycles 3..5 wait states, ack in cycle 6
    for (int i = 0; i < 4; i++) begin
      tick();
      if (i == 3) begin
        imem_ack = 1'b1; imem_rdata = 32'h11111111; instr_ready = 1'b0;
      end
      #1;
      chk("ws_req", 32'(imem_req), 32'd1);
      chk("ws_addr", 32'(imem_addr), 32'h004);
      chk("ws_next", 32'(next_address), 32'h004);
      chk("ws_valid", 32'(instr_valid), 32'd0);
    end

    // cycles 7..11: decode stalls
    for (int i = 0; i < 5; i++) begin
      tick();
      imem_ack = 1'b0;
      #1;
      chk("st_valid", 32'(instr_valid), 32'd1);
      chk("st_instr", instr, 32'h11111111);
      chk("st_next", 32'(next_address), 32'h004);
      chk("st_req", 32'(imem_req), 32'd0);
    end

    // cycle 12: ready rises, increment same cycle
    tick();
    instr_ready = 1'b1;
    #1;
    chk("c12_next", 32'(next_address), 32'h008);

    // cycle 13: redirect during REQ wait is only latched
    tick();
    instr_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 12'h100;
    #1;
    chk("c13_req", 32'(imem_req), 32'd1);
    chk("c13_addr", 32'(imem_addr), 32'h008);
    chk("c13_next", 32'(next_address), 32'h008);

    tick();
    redirect_valid = 1'b0;
    #1;
    chk("c14_next", 32'(next_address), 32'h008);
    chk("c14_req", 32'(imem_req), 32'd1);

    // cycle 15: ack data discarded, pending target loaded
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hDEADBEEF;
    #1;
    chk("c15_next", 32'(next_address), 32'h100);

    // cycle 16: refetch at 0x100, discarded word never valid
    tick();
    imem_ack = 1'b1; imem_rdata = 32'hAAAA0001;
    #1;
    chk("c16_valid", 32'(instr_valid), 32'd0);
    chk("c16_req", 32'(imem_req), 32'd1);
    chk("c16_addr", 32'(imem_addr), 32'h100);
    chk("c16_fault", 32'(misaligned_fault), 32'd0);

    // cycle 17: redirect beats increment in HOLD
    tick();
    imem_ack = 1'b0; instr_ready = 1'b1; redirect_valid = 1'b1; redirect_target = 12'hFFC;
    #1;
    chk("c17_instr", instr, 32'hAAAA0001);
    chk("c17_next", 32'(next_address), 32'hFFC);

    tick();
    redirect_valid = 1'b0; imem_ack = 1'b1; imem_rdata = 32'h00000013;
    #1;
    chk("c18_addr", 32'(imem_addr), 32'hFFC);
    chk("c18_valid", 32'(instr_valid), 32'd0);

    // cycle 19: PC wraps 0xFFC -> 0x000
    tick();
    imem_ack = 1'b0;
    #1;
    chk("c19_instr", instr, 32'h00000013);
    chk("c19_next", 32'(next_address), 32'h000);

    tick();
    imem_ack = 1'b1; imem_rdata = 32'h00500093;
    #1;
    chk("c20_addr", 32'(imem_addr), 32'h000);

    // cycle 21: misaligned redirect 0x0A6
    tick();
    imem_ack = 1'b0; instr_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 12'h0A6;
    #1;
    chk("c21_next", 32'(next_address), 32'h0A4);
    chk("c21_fault", 32'(misaligned_fault), 32'd0);

    tick();
    redirect_valid = 1'b0;
    #1;
    chk("c22_fault", 32'(misaligned_fault), 32'd1);
    chk("c22_addr", 32'(imem_addr), 32'h0A4);
    chk("c22_valid", 32'(instr_valid), 32'd0);

    tick();
    #1;
    chk("c23_fault", 32'(misaligned_fault), 32'd0);
    chk("c23_req", 32'(imem_req), 32'd1);

    // reset mid-REQ clears immediately
    rst = 1'b1;
    #1;
    chk("mr_req", 32'(imem_req), 32'd0);
    chk("mr_valid", 32'(instr_valid), 32'd0);
    chk("mr_next", 32'(next_address), 32'h000);

    tick();
    rst = 1'b0;
    #1;
    chk("mr_c0_req", 32'(imem_req), 32'd0);

    tick();
    #1;
    chk("mr_c1_req", 32'(imem_req), 32'd1);
    chk("mr_c1_addr", 32'(imem_addr), 32'h000);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/instruction_fetch_unit.md
Name: instruction_fetch_unit

Overview:
- Sits directly upstream of the program counter: computes the next address it registers, and fetches the instruction at the current address from instruction memory.
- Uses a req/ack handshake to instruction memory, with variable wait states.
- Hands the fetched word to decode with a valid/ready handshake.
- Holds the PC whenever fetch or decode stalls, and applies branch/jump redirects.

Parameters:
- ADDR_WIDTH, 12, byte address width; matches the program counter.
- DATA_WIDTH, 32, instruction word width.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- current_address  input  ADDR_WIDTH  registered PC value.
- next_address  output  ADDR_WIDTH  value the PC loads on the next clk edge.
- imem_req  output  1  instruction memory read request.
- imem_addr  output  ADDR_WIDTH  read address; equals current_address.
- imem_ack  input  1  memory has returned data this cycle.
- imem_rdata  input  DATA_WIDTH  read data, valid when imem_ack is high.
- instr  output  DATA_WIDTH  fetched instruction to decode.
- instr_valid  output  1  instr holds a valid word.
- instr_ready  input  1  decode accepts instr this cycle.
- redirect_valid  input  1  branch/jump taken, single-cycle pulse.
- redirect_target  input  ADDR_WIDTH  redirect destination.
- misaligned_fault  output  1  one-cycle pulse when an accepted redirect_target[1:0] != 0.

Behaviour:
- Reset values (async, immediate): state IDLE, imem_req 0, instr 0, instr_valid 0, misaligned_fault 0, redirect pending flag 0, pending target 0.
- next_address, imem_addr: combinational. All other outputs registered.
- Default next_address = current_address, so the PC holds. The PC advances only on the events listed below.
- PC increment: current_address + 4, modulo 2^ADDR_WIDTH (0xFFC -> 0x000). No carry out, no flag.
- IDLE:
  - Next cycle goes to REQ.
  - If a redirect is pending or redirect_valid is high: next_address = target and the pending flag clears.
- REQ:
  - imem_req = 1, held high with a stable address until imem_ack.
  - On imem_ack with no redirect pending and redirect_valid low: capture imem_rdata into instr, set instr_valid next edge, go HOLD.
  - On imem_ack with a redirect pending or redirect_valid high: discard rdata, next_address = target, pending clears, stay REQ.
  - The new address is presented one cycle later, with imem_req held high throughout.
  - An outstanding request is never cancelled.
- HOLD:
  - instr_valid = 1; instr stays stable until the handshake.
  - instr_valid & instr_ready with no redirect: next_address = current_address + 4, instr_valid clears, go REQ.
  - redirect_valid (with or without instr_ready): next_address = target, instr_valid clears, go REQ. Redirect wins over increment.
- Redirect capture:
  - redirect_valid in REQ without imem_ack latches the target into the pending register.
  - A newer redirect overwrites an older one (latest wins).
- Target alignment:
  - Bits [1:0] of any accepted target are forced to 00.
  - If the original bits were non-zero, misaligned_fault pulses for one cycle, registered on the acceptance edge.
- Throughput and latency:
  - Zero-wait memory (ack in the first REQ cycle) gives instr_valid one cycle after req rises.
  - Peak rate is one instruction per 2 cycles.
  - First imem_req rises 1 cycle after rst deasserts.
- Reset mid-operation:
  - All state clears asynchronously and the outstanding request is abandoned.
  - Memory must tolerate req dropping before ack.
  - The PC also resets, so fetch restarts from address 0.

Decomposition:
- Package fetch_pkg:
  - fetch_state_t enum {IDLE, REQ, HOLD}.
  - INSTR_BYTES = 4.
  - ALIGN_MASK constant.
- Sub-module fetch_next_pc: purely combinational next_address select.
  - Inputs: hold, increment, redirect, current_address, target.
  - Priority: redirect > increment > hold.
  - Includes alignment masking and fault detection.
- Top: FSM, instr/valid registers, pending-redirect register.

Test Plan:
- Reset release, PC at 0x000, memory acks on the first req cycle with 0x20080005, instr_ready = 1 -> req high at cycle 1, instr = 0x20080005 with valid at cycle 2, next_address = 0x004 that cycle.
- Memory inserts 3 wait cycles -> imem_req stays high with imem_addr stable at 0x004 for 4 cycles, next_address = current_address throughout, no valid until ack.
- instr_ready low for 5 cycles in HOLD -> instr and instr_valid stable, PC held; ready rises -> next_address = PC+4 in that same cycle.
- redirect_valid with target 0x100 during REQ wait, ack 2 cycles later with 0xDEADBEEF -> data discarded, instr_valid never set for it, next fetch at 0x100.
- PC = 0xFFC, instruction consumed -> next_address = 0x000. Redirect target 0x0A6 -> PC loads 0x0A4, misaligned_fault is high for exactly 1 cycle.
- rst asserted mid-REQ -> imem_req, instr_valid and state clear immediately; after release, the first req goes to 0x000 one cycle later.
